// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard unit: stall/bubble control, Tuse/Tnew forwarding
//             selects and mult/div busy scheduling with a stall perf counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_rs_addr,
    input  logic [4:0]  E_rt_addr,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic        E_md_start,
    input  logic        E_is_div,
    input  logic [4:0]  M_rt_addr,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic [4:0]  W_A3,
    output logic        F_PC_en,
    output logic        FD_en,
    output logic        DE_rst,
    output logic [1:0]  D_rs_fw,
    output logic [1:0]  D_rt_fw,
    output logic [1:0]  E_rs_fw,
    output logic [1:0]  E_rt_fw,
    output logic        M_rt_fw,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             w_stall_rs, w_stall_rt, w_stall_md, w_stall;

    // Register $0 is hard-wired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic dep_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                       input logic [4:0] m_a3, input logic [1:0] m_tnew);
        return (hit(src, e_a3) && (e_tnew > tuse)) || (hit(src, m_a3) && (m_tnew > tuse));
    endfunction

    // A matching producer that is not ready yet masks older producers.
    function automatic logic [1:0] d_sel(input logic [4:0] src,
                                         input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                         input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                         input logic [4:0] w_a3);
        if (hit(src, e_a3))      return (e_tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (hit(src, m_a3)) return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (hit(src, w_a3)) return 2'd3;
        else                     return 2'd0;
    endfunction

    function automatic logic [1:0] e_sel(input logic [4:0] src,
                                         input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                         input logic [4:0] w_a3);
        if (hit(src, m_a3))      return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (hit(src, w_a3)) return 2'd3;
        else                     return 2'd0;
    endfunction

    always_comb begin
        w_stall_rs = dep_stall(D_rs_addr, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
        w_stall_rt = dep_stall(D_rt_addr, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
        w_stall_md = D_is_md && (md_busy || E_md_start);
        w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

        F_PC_en = ~w_stall;
        FD_en   = ~w_stall;
        DE_rst  = w_stall || reset;

        D_rs_fw = d_sel(D_rs_addr, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        D_rt_fw = d_sel(D_rt_addr, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        E_rs_fw = e_sel(E_rs_addr, M_A3, M_Tnew, W_A3);
        E_rt_fw = e_sel(E_rt_addr, M_A3, M_Tnew, W_A3);
        M_rt_fw = hit(M_rt_addr, W_A3);
    end

    // A start seen while busy is ignored; the D-stage interlock prevents it.
    always_comb begin
        cnt_d = cnt_q;
        if (E_md_start && (cnt_q == '0)) begin
            cnt_d = E_is_div ? c_DIV_LOAD : c_MULT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy      = (cnt_q != '0);
    assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl: vector table plus
//             multi-cycle mult/div and reset sequences, scoreboard-checked.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
    logic [1:0]  tuse_rs, tuse_rt, e_tnew, m_tnew;
    logic        d_md, e_start, e_div;
    logic        f_pc_en, fd_en, de_rst, m_rt_fw, md_busy;
    logic [1:0]  d_rs_fw, d_rt_fw, e_rs_fw, e_rt_fw;
    logic [31:0] stall_cycles;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(d_rs), .D_rt_addr(d_rt), .D_Tuse_rs(tuse_rs), .D_Tuse_rt(tuse_rt),
        .D_is_md(d_md),
        .E_rs_addr(e_rs), .E_rt_addr(e_rt), .E_A3(e_a3), .E_Tnew(e_tnew),
        .E_md_start(e_start), .E_is_div(e_div),
        .M_rt_addr(m_rt), .M_A3(m_a3), .M_Tnew(m_tnew), .W_A3(w_a3),
        .F_PC_en(f_pc_en), .FD_en(fd_en), .DE_rst(de_rst),
        .D_rs_fw(d_rs_fw), .D_rt_fw(d_rt_fw), .E_rs_fw(e_rs_fw), .E_rt_fw(e_rt_fw),
        .M_rt_fw(m_rt_fw), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] d_rs, d_rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic       d_md;
        logic [4:0] e_rs, e_rt, e_a3;
        logic [1:0] e_tnew;
        logic [4:0] m_rt, m_a3;
        logic [1:0] m_tnew;
        logic [4:0] w_a3;
        logic       stall;
        logic [1:0] drs, drt, ers, ert;
        logic       mrt;
    } vec_t;

    typedef struct {
        logic        pc_en, de_rst, busy, mrt;
        logic [1:0]  drs, drt, ers, ert;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[12];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sc_model = 0;
    int          step_no  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL step%0d %s: got %0h expected %0h", step_no, name, act, want);
        end
    endtask

    task automatic clr();
        reset = 1'b0; d_rs = 0; d_rt = 0; tuse_rs = 2'd3; tuse_rt = 2'd3; d_md = 0;
        e_rs = 0; e_rt = 0; e_a3 = 0; e_tnew = 0; e_start = 0; e_div = 0;
        m_rt = 0; m_a3 = 0; m_tnew = 0; w_a3 = 0;
    endtask

    // Inputs are already applied; expectation is queued, checked mid-cycle,
    // then the clock edge commits state and the counter model follows it.
    task automatic step(input logic stall, input logic busy, input logic [1:0] drs,
                        input logic [1:0] drt, input logic [1:0] ers,
                        input logic [1:0] ert, input logic mrt);
        exp_t e;
        e.pc_en = ~stall; e.de_rst = stall | reset; e.busy = busy;
        e.drs = drs; e.drt = drt; e.ers = ers; e.ert = ert; e.mrt = mrt;
        e.sc = sc_model;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("F_PC_en", 32'(f_pc_en), 32'(e.pc_en));
        chk("FD_en", 32'(fd_en), 32'(e.pc_en));
        chk("DE_rst", 32'(de_rst), 32'(e.de_rst));
        chk("md_busy", 32'(md_busy), 32'(e.busy));
        chk("D_rs_fw", 32'(d_rs_fw), 32'(e.drs));
        chk("D_rt_fw", 32'(d_rt_fw), 32'(e.drt));
        chk("E_rs_fw", 32'(e_rs_fw), 32'(e.ers));
        chk("E_rt_fw", 32'(e_rt_fw), 32'(e.ert));
        chk("M_rt_fw", 32'(m_rt_fw), 32'(e.mrt));
        chk("stall_cycles", stall_cycles, e.sc);
        if (reset) sc_model = 0;
        else if (stall) sc_model = sc_model + 1;
        @(posedge clk);
        #1;
        step_no++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // d_rs d_rt tuse_rs tuse_rt d_md | e_rs e_rt e_a3 e_tnew | m_rt m_a3 m_tnew | w_a3
        // | stall drs drt ers ert mrt
        tbl[0]  = '{0, 0, 3, 3, 0,   0,  0,  0, 0,   0,  0, 0,   0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 3, 0,   0,  0,  1, 2,   0,  0, 0,   0,  1, 0, 0, 0, 0, 0};
        tbl[2]  = '{2, 0, 0, 3, 0,   0,  0,  2, 0,   0,  0, 0,   0,  0, 1, 0, 0, 0, 0};
        tbl[3]  = '{3, 0, 1, 3, 0,   3,  0,  3, 1,   0,  3, 0,   3,  0, 0, 0, 2, 0, 0};
        tbl[4]  = '{0, 0, 3, 3, 0,   4,  4,  0, 0,   0,  4, 1,   4,  0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 5, 3, 0, 0,   5,  6,  0, 0,   5,  0, 0,   5,  0, 0, 3, 3, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0,   0,  0,  0, 2,   0,  0, 0,   0,  0, 0, 0, 0, 0, 0};
        tbl[7]  = '{8, 7, 3, 0, 0,   0,  0,  0, 0,   0,  7, 1,   8,  1, 3, 0, 0, 0, 0};
        tbl[8]  = '{9, 10, 2, 2, 0,  0,  0, 10, 2,   0,  9, 0,   0,  0, 2, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 3, 3, 1,   0,  0,  0, 0,   0,  0, 0,   0,  0, 0, 0, 0, 0, 0};
        tbl[10] = '{11, 0, 0, 3, 0,  0,  0, 11, 1,  12,  0, 0,  12,  1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 3, 3, 0,  14, 13,  0, 0,   0, 13, 0,  14,  0, 0, 0, 3, 2, 0};

        clr();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            d_rs = tbl[i].d_rs; d_rt = tbl[i].d_rt;
            tuse_rs = tbl[i].tuse_rs; tuse_rt = tbl[i].tuse_rt; d_md = tbl[i].d_md;
            e_rs = tbl[i].e_rs; e_rt = tbl[i].e_rt; e_a3 = tbl[i].e_a3; e_tnew = tbl[i].e_tnew;
            m_rt = tbl[i].m_rt; m_a3 = tbl[i].m_a3; m_tnew = tbl[i].m_tnew; w_a3 = tbl[i].w_a3;
            step(tbl[i].stall, 0, tbl[i].drs, tbl[i].drt, tbl[i].ers, tbl[i].ert, tbl[i].mrt);
        end

        // Load-use: lw $1 in E stalls addu; after the bubble $1 comes from M.
        clr(); d_rs = 1; tuse_rs = 1; e_a3 = 1; e_tnew = 2;
        step(1, 0, 0, 0, 0, 0, 0);
        clr(); d_rs = 1; tuse_rs = 1; m_a3 = 1; m_tnew = 0;
        step(0, 0, 2, 0, 0, 0, 0);

        // div in E with mflo in D: 11 stalled cycles from a cleared counter.
        clr(); reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        clr(); d_md = 1; e_start = 1; e_div = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        clr(); d_md = 1;
        for (int k = 0; k < 10; k++) step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("div_total_stalls", sc_model, 32'd11);

        // mult with $0 in both D source and E dest: busy 5 cycles, no stall.
        clr(); e_start = 1; e_tnew = 2;
        step(0, 0, 0, 0, 0, 0, 0);
        clr(); e_tnew = 2;
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset while the divider counter holds 7.
        clr(); d_md = 1; e_start = 1; e_div = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        clr(); d_md = 1;
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0);
        clr(); reset = 1'b1;
        step(0, 1, 0, 0, 0, 0, 0);
        clr();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
